ws2812_decoder: RTL and testbench

Single-wire WS2812 (NZR, 800 kHz) receiver. It recovers 24-bit GRB pixel words from a serial LED-chain stream and reports them one pixel at a time with an index. It also detects frame latch gaps and line errors. It sits on the `clk_w` domain beside the existing WS2812 transmitter and serves as loopback/self-test sink and as an input for an external LED-stream capture port.

---
 rtl/ws2812_decoder.sv | 192 +++++++++++++++++++
 tb/tb_ws2812_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_decoder.sv
// ws2812_decoder
// Single-wire WS2812 (NZR, 800 kHz) receiver. Recovers 24-bit GRB pixel
// words from a serial LED-chain stream, reports them one pixel at a time
// with a frame-relative index, and flags latch gaps and line errors.
//
// Ports:
//   clk          - system clock, all logic on the rising edge
//   reset_n      - asynchronous active-low reset
//   din          - raw WS2812 data line, asynchronous to clk
//   pixel_valid  - one-cycle strobe, pixel_grb/pixel_index valid
//   pixel_grb    - decoded word, first received bit in [23]
//   pixel_index  - position of this pixel in the current frame (mod 256)
//   frame_done   - one-cycle strobe at a latch gap ending a non-empty frame
//   frame_pixels - complete pixels in the last finished frame (saturates 511)
//   line_error   - one-cycle strobe on over-long high or partial-pixel discard
module ws2812_decoder #(
   parameter int T_MIN    = 4,
   parameter int T_THRESH = 16,
   parameter int T_HMAX   = 54,
   parameter int T_RESET  = 1350
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        din,
   output logic        pixel_valid,
   output logic [23:0] pixel_grb,
   output logic [7:0]  pixel_index,
   output logic        frame_done,
   output logic [8:0]  frame_pixels,
   output logic        line_error
);

   localparam int HW = $clog2(T_HMAX + 1);
   localparam int LW = $clog2(T_RESET + 1);

   localparam logic [HW-1:0] H_MIN    = HW'(T_MIN);
   localparam logic [HW-1:0] H_THRESH = HW'(T_THRESH);
   localparam logic [HW-1:0] H_LAST   = HW'(T_HMAX - 1);
   localparam logic [LW-1:0] L_RESET  = LW'(T_RESET);
   localparam logic [LW-1:0] L_LAST   = LW'(T_RESET - 1);

   typedef enum logic [1:0] {
      SYNC,
      LOW,
      HIGH
   } state_t;

   state_t        state;
   logic          din_meta;
   logic          din_s;
   logic [HW-1:0] hcnt;
   logic [LW-1:0] lcnt;
   logic [4:0]    bcnt;
   logic [8:0]    pcnt;
   logic [23:0]   shreg;
   logic          pix_pend;
   logic [23:0]   pix_word;
   logic [7:0]    pix_idx;

   logic          bit_val;
   logic [23:0]   shift_next;

   // The width of the high pulse that just ended decides the bit value, and
   // the word that would result if this bit is shifted in is formed here so
   // the 24th bit can be captured in the same cycle it is decoded.
   assign bit_val    = (hcnt >= H_THRESH);
   assign shift_next = {shreg[22:0], bit_val};

   // Two-flop synchronizer for the asynchronous data line; everything
   // downstream only ever looks at din_s.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         din_meta <= 1'b0;
         din_s    <= 1'b0;
      end else begin
         din_meta <= din;
         din_s    <= din_meta;
      end
   end

   // Decoder state machine. The LOW/HIGH state doubles as the previous
   // value of din_s, so a state/level mismatch is the edge detector.
   // SYNC waits for a full latch gap before trusting any data, which is
   // how we recover from power-up mid-stream and from over-long highs.
   // The latch event is tied to lcnt stepping onto T_RESET; lcnt then
   // saturates there, so one gap fires exactly once, and a glitch inside
   // the gap cannot re-arm it because lcnt is left untouched in HIGH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= SYNC;
         hcnt         <= '0;
         lcnt         <= '0;
         bcnt         <= '0;
         pcnt         <= '0;
         shreg        <= '0;
         pix_pend     <= 1'b0;
         pix_word     <= '0;
         pix_idx      <= '0;
         frame_done   <= 1'b0;
         frame_pixels <= '0;
         line_error   <= 1'b0;
      end else begin
         pix_pend   <= 1'b0;
         frame_done <= 1'b0;
         line_error <= 1'b0;
         case (state)
            SYNC: begin
               if (din_s) begin
                  lcnt <= '0;
               end else if (lcnt == L_LAST) begin
                  lcnt  <= L_RESET;
                  bcnt  <= '0;
                  pcnt  <= '0;
                  state <= LOW;
               end else begin
                  lcnt <= lcnt + 1'b1;
               end
            end
            LOW: begin
               if (din_s) begin
                  hcnt  <= HW'(1);
                  state <= HIGH;
               end else if (lcnt != L_RESET) begin
                  lcnt <= lcnt + 1'b1;
                  if (lcnt == L_LAST) begin
                     if (bcnt != 5'd0) begin
                        line_error <= 1'b1;
                     end
                     if (pcnt != 9'd0) begin
                        frame_done   <= 1'b1;
                        frame_pixels <= pcnt;
                     end
                     bcnt <= '0;
                     pcnt <= '0;
                  end
               end
            end
            HIGH: begin
               if (din_s) begin
                  if (hcnt == H_LAST) begin
                     line_error <= 1'b1;
                     bcnt       <= '0;
                     pcnt       <= '0;
                     lcnt       <= '0;
                     state      <= SYNC;
                  end else begin
                     hcnt <= hcnt + 1'b1;
                  end
               end else if (hcnt < H_MIN) begin
                  state <= LOW;
               end else begin
                  shreg <= shift_next;
                  lcnt  <= '0;
                  state <= LOW;
                  if (bcnt == 5'd23) begin
                     bcnt     <= '0;
                     pix_pend <= 1'b1;
                     pix_word <= shift_next;
                     pix_idx  <= pcnt[7:0];
                     if (pcnt != 9'h1FF) begin
                        pcnt <= pcnt + 1'b1;
                     end
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= SYNC;
            end
         endcase
      end
   end

   // Pixel output stage. One register between the decoder and the port
   // puts pixel_valid three edges after the synchronizer first sees the
   // final falling edge, and keeps word/index stable between strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pixel_valid <= 1'b0;
         pixel_grb   <= '0;
         pixel_index <= '0;
      end else begin
         pixel_valid <= pix_pend;
         if (pix_pend) begin
            pixel_grb   <= pix_word;
            pixel_index <= pix_idx;
         end
      end
   end

endmodule

// File: tb/tb_ws2812_decoder.sv
// tb_ws2812_decoder
// Self-checking bench for ws2812_decoder. A table of pixel vectors is
// streamed through the serial line; expected pixels and frame counts are
// queued as stimulus is driven and compared when the DUT strobes them.
// Hand-written sequences cover glitches, over-long highs, partial pixels,
// a stream without leading gap and reset mid-pixel.
module tb_ws2812_decoder;

   localparam int PERIOD = 34;
   localparam int H0     = 8;
   localparam int H1     = 20;
   localparam int GAP    = 1400;

   logic        clk;
   logic        reset_n;
   logic        din;
   logic        pixel_valid;
   logic [23:0] pixel_grb;
   logic [7:0]  pixel_index;
   logic        frame_done;
   logic [8:0]  frame_pixels;
   logic        line_error;

   typedef struct packed {
      logic [23:0] grb;
      logic [7:0]  idx;
   } pix_t;

   typedef struct {
      logic [23:0] word;
      logic [7:0]  exp_index;
      logic        gap_after;
      logic [8:0]  exp_frame;
   } vec_t;

   pix_t       pix_q[$];
   logic [8:0] frame_q[$];
   vec_t       vecs[5];

   int n_vec;
   int n_miss;
   int cyc;
   int err_seen;
   int last_err_cyc;
   int last_fd_cyc;

   ws2812_decoder dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .din          (din),
      .pixel_valid  (pixel_valid),
      .pixel_grb    (pixel_grb),
      .pixel_index  (pixel_index),
      .frame_done   (frame_done),
      .frame_pixels (frame_pixels),
      .line_error   (line_error)
   );

   // Free-running clock plus a cycle counter used to line up strobes.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One comparison: counts it, and reports it when it does not match.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_miss = n_miss + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one NZR bit: high for the 0/1 width, then low for the rest of
   // the period. An optional 2-cycle high glitch sits inside the low part.
   task automatic applyStimulus(input logic b, input logic glitch);
      int h;
      h = b ? H1 : H0;
      din = 1'b1;
      repeat (h) @(negedge clk);
      din = 1'b0;
      if (glitch) begin
         repeat (5) @(negedge clk);
         din = 1'b1;
         repeat (2) @(negedge clk);
         din = 1'b0;
         repeat (PERIOD - h - 7) @(negedge clk);
      end else begin
         repeat (PERIOD - h) @(negedge clk);
      end
   endtask

   // Send the top n bits of a word, MSB first.
   task automatic send_bits(input logic [23:0] w, input int n, input logic glitch);
      for (int i = 23; i > 23 - n; i--) begin
         applyStimulus(w[i], glitch);
      end
   endtask

   task automatic send_gap(input int len);
      din = 1'b0;
      repeat (len) @(negedge clk);
   endtask

   task automatic expect_pixel(input logic [23:0] w, input logic [7:0] idx);
      pix_t p;
      p.grb = w;
      p.idx = idx;
      pix_q.push_back(p);
   endtask

   task automatic check_reset_outputs(input string tag);
      checkOutput({tag, "_valid"}, {31'd0, pixel_valid}, 32'd0);
      checkOutput({tag, "_grb"}, {8'd0, pixel_grb}, 32'd0);
      checkOutput({tag, "_index"}, {24'd0, pixel_index}, 32'd0);
      checkOutput({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
      checkOutput({tag, "_frame_pixels"}, {23'd0, frame_pixels}, 32'd0);
      checkOutput({tag, "_line_error"}, {31'd0, line_error}, 32'd0);
   endtask

   // Scoreboard: sampled on the falling edge, away from the active edge.
   // Every pixel/frame strobe must match the head of its queue; an empty
   // queue at a strobe means the DUT produced output it should not have.
   always @(negedge clk) begin
      if (reset_n) begin
         if (pixel_valid) begin
            checkOutput("pixel_expected", {31'd0, pix_q.size() != 0}, 32'd1);
            if (pix_q.size() != 0) begin
               pix_t p;
               p = pix_q.pop_front();
               checkOutput("pixel_grb", {8'd0, pixel_grb}, {8'd0, p.grb});
               checkOutput("pixel_index", {24'd0, pixel_index}, {24'd0, p.idx});
            end
         end
         if (frame_done) begin
            last_fd_cyc = cyc;
            checkOutput("frame_expected", {31'd0, frame_q.size() != 0}, 32'd1);
            if (frame_q.size() != 0) begin
               logic [8:0] f;
               f = frame_q.pop_front();
               checkOutput("frame_pixels", {23'd0, frame_pixels}, {23'd0, f});
            end
         end
         if (line_error) begin
            err_seen     = err_seen + 1;
            last_err_cyc = cyc;
         end
      end
   end

   initial begin
      int err_before;

      vecs[0] = '{24'hA53C0F, 8'd0, 1'b1, 9'd1};
      vecs[1] = '{24'hFF0000, 8'd0, 1'b0, 9'd0};
      vecs[2] = '{24'h00FF00, 8'd1, 1'b0, 9'd0};
      vecs[3] = '{24'h0000FF, 8'd2, 1'b1, 9'd3};
      vecs[4] = '{24'h00C0DE, 8'd0, 1'b1, 9'd1};

      n_vec        = 0;
      n_miss       = 0;
      cyc          = 0;
      err_seen     = 0;
      last_err_cyc = -1;
      last_fd_cyc  = -2;
      din          = 1'b0;
      reset_n      = 1'b0;
      repeat (5) @(negedge clk);
      check_reset_outputs("reset");

      // Stream active straight out of reset: nothing may decode until the
      // first full latch gap, and that gap must not raise frame_done.
      reset_n = 1'b1;
      send_bits(24'hDEAD00, 24, 1'b0);
      send_gap(GAP);
      checkOutput("nogap_errors", err_seen, 0);

      // Table-driven pixels and frames.
      for (int v = 0; v < 5; v++) begin
         expect_pixel(vecs[v].word, vecs[v].exp_index);
         send_bits(vecs[v].word, 24, 1'b0);
         if (vecs[v].gap_after) begin
            frame_q.push_back(vecs[v].exp_frame);
            send_gap(GAP);
         end
      end
      checkOutput("table_errors", err_seen, 0);

      // Short high glitches between valid bits are ignored.
      expect_pixel(24'h123456, 8'd0);
      send_bits(24'h123456, 24, 1'b1);
      frame_q.push_back(9'd1);
      send_gap(GAP);
      checkOutput("glitch_errors", err_seen, 0);

      // Over-long high mid-pixel: error, resync, then index restarts at 0.
      err_before = err_seen;
      send_bits(24'h3C3C3C, 10, 1'b0);
      din = 1'b1;
      repeat (60) @(negedge clk);
      send_gap(GAP);
      checkOutput("overlong_error", err_seen - err_before, 1);
      expect_pixel(24'h0F0F0F, 8'd0);
      send_bits(24'h0F0F0F, 24, 1'b0);
      frame_q.push_back(9'd1);
      send_gap(GAP);

      // Partial pixel alone: error, no frame_done.
      err_before = err_seen;
      send_bits(24'hFFFFFF, 10, 1'b0);
      send_gap(GAP);
      checkOutput("partial_error", err_seen - err_before, 1);

      // One pixel plus five bits: error and frame_done in the same cycle.
      err_before = err_seen;
      expect_pixel(24'h81C3E7, 8'd0);
      send_bits(24'h81C3E7, 24, 1'b0);
      send_bits(24'hF00000, 5, 1'b0);
      frame_q.push_back(9'd1);
      send_gap(GAP);
      checkOutput("partial_frame_error", err_seen - err_before, 1);
      checkOutput("error_frame_same_cycle", last_err_cyc, last_fd_cyc);

      // Reset mid-pixel clears all outputs immediately.
      send_bits(24'hAAAAAA, 12, 1'b0);
      din     = 1'b1;
      reset_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      din = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      send_gap(GAP);
      expect_pixel(24'h5A5A5A, 8'd0);
      send_bits(24'h5A5A5A, 24, 1'b0);
      frame_q.push_back(9'd1);
      send_gap(GAP);

      checkOutput("pixels_drained", pix_q.size(), 0);
      checkOutput("frames_drained", frame_q.size(), 0);
      checkOutput("total_errors", err_seen, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
